stopit_controller: RTL and testbench
====================================

STOPIT_CONTROLLER -- requirements
Module: stopit_controller

Interface
REQ-001 Parameter TOLERANCE, default 1: maximum allowed |elapsed - target| for a win.
REQ-002 Parameter RESULT_CYCLES, default 8: number of cycles the WON or LOST result is held before the block returns to IDLE.
REQ-003 clk_4_i  input  1  4 Hz game clock; the only clock.
REQ-004 rst_i  input  1  synchronous, active-high reset.
REQ-005 start_i  input  1  single-cycle, already-debounced start pulse.
REQ-006 stop_i  input  1  single-cycle, already-debounced stop pulse.
REQ-007 running_o  output  1  high while in COUNTING.
REQ-008 won_o  output  1  high while in WON.
REQ-009 lost_o  output  1  high while in LOST.
REQ-010 elapsed_o  output  5  current elapsed-tick count.
REQ-011 target_o  output  5  target tick count for the current round.
REQ-012 score_o  output  4  consecutive-win streak.

Function
REQ-013 The block SHALL implement four states: IDLE, COUNTING, WON and LOST.
REQ-014 IDLE: on start_i, the block SHALL load target = lfsr[3:0] + 8 (range 8..23), clear elapsed to 0 and enter COUNTING on the next cycle.
REQ-015 IDLE: stop_i SHALL be ignored.
REQ-016 COUNTING, stop_i=0, elapsed<31: elapsed SHALL increment by 1 each cycle.
REQ-017 COUNTING, stop_i=1: the block SHALL freeze elapsed and compare the elapsed value sampled in that same cycle against target.
- |elapsed - target| <= TOLERANCE -> WON.
- Otherwise -> LOST.
- The difference SHALL be computed as unsigned and must not wrap.
REQ-018 COUNTING, elapsed==31 with stop_i=0: the block SHALL enter LOST (timeout), with elapsed held at 31.
REQ-019 COUNTING: start_i SHALL be ignored; when start_i and stop_i arrive in the same cycle, stop_i takes priority.
REQ-020 WON/LOST: a hold counter SHALL count RESULT_CYCLES cycles, then the block returns to IDLE.
REQ-021 WON/LOST: start_i SHALL abort the hold and start a new round immediately, exactly as REQ-014.
REQ-022 WON/LOST: elapsed_o and target_o SHALL hold their final values until the next start.
REQ-023 Score on entry to WON: score SHALL increment, saturating at 15.
REQ-024 Score on entry to LOST: score SHALL clear to 0.
REQ-025 All outputs SHALL be registered or decoded only from registered state, so that start_i and stop_i have no combinational path to any output.
REQ-026 The LFSR SHALL advance every cycle in every state, so that the target depends on when start_i is pressed.

Reset
REQ-027 While rst_i is high at a rising clk_4_i edge, the block SHALL apply all of the following:
- state = IDLE.
- elapsed_o = 0, target_o = 0, score_o = 0.
- running_o, won_o and lost_o = 0.
- hold counter = 0.
- LFSR = 16'hACE1.
REQ-028 Reset asserted mid-round SHALL abandon the round with no score change other than clearing to 0.
REQ-029 The block SHALL ignore start_i in the cycle rst_i is high.

Structure
REQ-030 A shared package stopit_pkg SHALL hold the state enum type and the constants TARGET_OFFSET=8, ELAPSED_MAX=31 and LFSR_SEED=16'hACE1.
REQ-031 A sub-module lfsr16 SHALL implement the 16-bit Fibonacci LFSR:
- Taps at bits 16, 14, 13 and 11.
- Synchronous load of LFSR_SEED on reset.
- Free-running.
REQ-032 The elapsed counter, hold counter and comparison logic SHALL reside in stopit_controller.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- Reset: hold rst_i 2 cycles -> all outputs 0; stop_i in IDLE -> no state change.
- Win on exact hit: start; read target_o=T; pulse stop_i when elapsed_o=T -> won_o=1 next cycle, score_o 0->1, elapsed_o frozen at T.
- Win/loss at the tolerance edge (TOLERANCE=1):
  - stop at T-1 -> won_o=1.
  - stop at T+2 -> lost_o=1, score_o=0.
- Timeout: start, no stop -> elapsed_o reaches 31, lost_o=1 the following cycle; after 8 cycles -> IDLE, all flags 0.
- Simultaneous start_i+stop_i in COUNTING -> stop evaluated; start_i during WON hold at cycle 3 -> running_o=1 next cycle, elapsed_o=0, score preserved.
- Saturation and reset mid-round:
  - 16 consecutive wins -> score_o=15, not 0.
  - rst_i during COUNTING -> IDLE, score_o=0.

Source files
------------

// File: rtl/stopit_pkg.sv
// Shared types and constants for the stop-it reaction game controller.
package stopit_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNTING = 2'd1,
        WON      = 2'd2,
        LOST     = 2'd3
    } state_t;

    localparam logic [4:0]  TARGET_OFFSET = 5'd8;
    localparam logic [4:0]  ELAPSED_MAX   = 5'd31;
    localparam logic [15:0] LFSR_SEED     = 16'hACE1;

    // Saturating increment for the 4-bit win streak.
    function automatic logic [3:0] satInc4(input logic [3:0] value);
        return (value == 4'd15) ? value : value + 4'd1;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), reseeded by reset.
module lfsr16
    import stopit_pkg::*;
#(
    parameter int unsigned OUT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic [OUT_W-1:0] value_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic        feedback;

    always_comb begin
        feedback = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        lfsr_d   = {lfsr_q[14:0], feedback};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value_o = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/stopit_controller.sv
// Stop-it game controller: counts ticks toward a pseudo-random target and scores the stop press.
module stopit_controller
    import stopit_pkg::*;
#(
    parameter int unsigned TOLERANCE     = 1,
    parameter int unsigned RESULT_CYCLES = 8
) (
    input  logic       clk_4_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       stop_i,
    output logic       running_o,
    output logic       won_o,
    output logic       lost_o,
    output logic [4:0] elapsed_o,
    output logic [4:0] target_o,
    output logic [3:0] score_o
);

    localparam logic [7:0] HOLD_LAST = 8'(RESULT_CYCLES - 1);

    state_t     state_q, state_d;
    logic [4:0] elapsed_q, elapsed_d;
    logic [4:0] target_q, target_d;
    logic [3:0] score_q, score_d;
    logic [7:0] holdCnt_q, holdCnt_d;
    logic [3:0] lfsrNibble;
    logic [4:0] distance;
    logic       inWindow;

    lfsr16 #(
        .OUT_W (4)
    ) u_lfsr (
        .clk_i   (clk_4_i),
        .rst_i   (rst_i),
        .value_o (lfsrNibble)
    );

    // Order the subtraction so the unsigned distance never wraps.
    always_comb begin
        distance = (elapsed_q >= target_q) ? (elapsed_q - target_q) : (target_q - elapsed_q);
        inWindow = (32'(distance) <= TOLERANCE);
    end

    always_comb begin
        state_d   = state_q;
        elapsed_d = elapsed_q;
        target_d  = target_q;
        score_d   = score_q;
        holdCnt_d = holdCnt_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d   = COUNTING;
                    target_d  = {1'b0, lfsrNibble} + TARGET_OFFSET;
                    elapsed_d = 5'd0;
                end
            end
            COUNTING: begin
                // Stop wins over a simultaneous start; elapsed freezes at the sampled value.
                if (stop_i) begin
                    holdCnt_d = 8'd0;
                    if (inWindow) begin
                        state_d = WON;
                        score_d = satInc4(score_q);
                    end else begin
                        state_d = LOST;
                        score_d = 4'd0;
                    end
                end else if (elapsed_q == ELAPSED_MAX) begin
                    state_d   = LOST;
                    score_d   = 4'd0;
                    holdCnt_d = 8'd0;
                end else begin
                    elapsed_d = elapsed_q + 5'd1;
                end
            end
            WON, LOST: begin
                if (start_i) begin
                    state_d   = COUNTING;
                    target_d  = {1'b0, lfsrNibble} + TARGET_OFFSET;
                    elapsed_d = 5'd0;
                    holdCnt_d = 8'd0;
                end else if (holdCnt_q == HOLD_LAST) begin
                    state_d   = IDLE;
                    holdCnt_d = 8'd0;
                end else begin
                    holdCnt_d = holdCnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_4_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            elapsed_q <= 5'd0;
            target_q  <= 5'd0;
            score_q   <= 4'd0;
            holdCnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            elapsed_q <= elapsed_d;
            target_q  <= target_d;
            score_q   <= score_d;
            holdCnt_q <= holdCnt_d;
        end
    end

    assign running_o = (state_q == COUNTING);
    assign won_o     = (state_q == WON);
    assign lost_o    = (state_q == LOST);
    assign elapsed_o = elapsed_q;
    assign target_o  = target_q;
    assign score_o   = score_q;

endmodule

// File: tb/tb_stopit_controller.sv
// Directed self-checking bench for stopit_controller: reset, wins, losses, timeout, abort, saturation.
module tb_stopit_controller;
    import stopit_pkg::*;

    logic       clk_4_i = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic       stop_i;
    logic       running_o;
    logic       won_o;
    logic       lost_o;
    logic [4:0] elapsed_o;
    logic [4:0] target_o;
    logic [3:0] score_o;

    logic [15:0] lfsrModel;
    logic [4:0]  expT;
    logic [3:0]  expScore;
    int          nAsserts = 0;
    int          nFails   = 0;

    stopit_controller #(
        .TOLERANCE     (1),
        .RESULT_CYCLES (8)
    ) dut (
        .clk_4_i   (clk_4_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .stop_i    (stop_i),
        .running_o (running_o),
        .won_o     (won_o),
        .lost_o    (lost_o),
        .elapsed_o (elapsed_o),
        .target_o  (target_o),
        .score_o   (score_o)
    );

    always #5 clk_4_i = ~clk_4_i;

    // Reference LFSR: taps 16,14,13,11, reseeded whenever reset is sampled.
    always @(posedge clk_4_i) begin
        if (rst_i) begin
            lfsrModel <= 16'hACE1;
        end else begin
            lfsrModel <= {lfsrModel[14:0], lfsrModel[15] ^ lfsrModel[13] ^ lfsrModel[12] ^ lfsrModel[10]};
        end
    end

    task automatic applyStimulus(input logic s, input logic p);
        start_i = s;
        stop_i  = p;
        @(posedge clk_4_i);
        #1;
        start_i = 1'b0;
        stop_i  = 1'b0;
    endtask

    task automatic runIdle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic startRound(input string tag);
        expT = 5'(lfsrModel[3:0]) + 5'd8;
        applyStimulus(1'b1, 1'b0);
        checkOutput({tag, "_running"}, 8'(running_o), 8'd1);
        checkOutput({tag, "_elapsed0"}, 8'(elapsed_o), 8'd0);
        checkOutput({tag, "_target"}, 8'(target_o), 8'(expT));
    endtask

    initial begin
        rst_i   = 1'b1;
        start_i = 1'b0;
        stop_i  = 1'b0;
        $display("[TB] starting stopit_controller bench");

        // Two reset cycles, with a start press during the second that must be ignored.
        @(posedge clk_4_i);
        #1;
        start_i = 1'b1;
        @(posedge clk_4_i);
        #1;
        start_i = 1'b0;
        checkOutput("rst_running", 8'(running_o), 8'd0);
        checkOutput("rst_won", 8'(won_o), 8'd0);
        checkOutput("rst_lost", 8'(lost_o), 8'd0);
        checkOutput("rst_elapsed", 8'(elapsed_o), 8'd0);
        checkOutput("rst_target", 8'(target_o), 8'd0);
        checkOutput("rst_score", 8'(score_o), 8'd0);
        rst_i = 1'b0;

        applyStimulus(1'b0, 1'b1);
        checkOutput("idle_stop_running", 8'(running_o), 8'd0);
        checkOutput("idle_stop_won", 8'(won_o), 8'd0);
        checkOutput("idle_stop_lost", 8'(lost_o), 8'd0);
        checkOutput("idle_stop_elapsed", 8'(elapsed_o), 8'd0);

        // Exact hit.
        startRound("exact");
        runIdle(int'(expT));
        checkOutput("exact_reach", 8'(elapsed_o), 8'(expT));
        applyStimulus(1'b0, 1'b1);
        checkOutput("exact_won", 8'(won_o), 8'd1);
        checkOutput("exact_notrunning", 8'(running_o), 8'd0);
        checkOutput("exact_score", 8'(score_o), 8'd1);
        checkOutput("exact_frozen", 8'(elapsed_o), 8'(expT));
        runIdle(1);
        checkOutput("exact_frozen2", 8'(elapsed_o), 8'(expT));
        checkOutput("exact_won2", 8'(won_o), 8'd1);

        // Stop one tick early: inside tolerance.
        startRound("early");
        checkOutput("early_score_kept", 8'(score_o), 8'd1);
        runIdle(int'(expT) - 1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("early_won", 8'(won_o), 8'd1);
        checkOutput("early_score", 8'(score_o), 8'd2);

        // Stop two ticks late: outside tolerance.
        startRound("late");
        runIdle(int'(expT) + 2);
        applyStimulus(1'b0, 1'b1);
        checkOutput("late_lost", 8'(lost_o), 8'd1);
        checkOutput("late_won", 8'(won_o), 8'd0);
        checkOutput("late_score", 8'(score_o), 8'd0);
        checkOutput("late_elapsed", 8'(elapsed_o), 8'(expT + 5'd2));

        // Timeout and full hold back to IDLE.
        startRound("tmo");
        runIdle(31);
        checkOutput("tmo_at31", 8'(elapsed_o), 8'd31);
        checkOutput("tmo_stillrunning", 8'(running_o), 8'd1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("tmo_lost", 8'(lost_o), 8'd1);
        checkOutput("tmo_running", 8'(running_o), 8'd0);
        checkOutput("tmo_held31", 8'(elapsed_o), 8'd31);
        runIdle(7);
        checkOutput("tmo_hold_last", 8'(lost_o), 8'd1);
        runIdle(1);
        checkOutput("tmo_idle_lost", 8'(lost_o), 8'd0);
        checkOutput("tmo_idle_won", 8'(won_o), 8'd0);
        checkOutput("tmo_idle_running", 8'(running_o), 8'd0);
        checkOutput("tmo_idle_elapsed", 8'(elapsed_o), 8'd31);
        checkOutput("tmo_idle_target", 8'(target_o), 8'(expT));

        // Simultaneous start+stop while counting: stop is evaluated.
        startRound("simul");
        runIdle(int'(expT));
        applyStimulus(1'b1, 1'b1);
        checkOutput("simul_won", 8'(won_o), 8'd1);
        checkOutput("simul_running", 8'(running_o), 8'd0);
        checkOutput("simul_score", 8'(score_o), 8'd1);
        checkOutput("simul_elapsed", 8'(elapsed_o), 8'(expT));

        // Abort the WON hold at its third cycle with a new start.
        runIdle(2);
        checkOutput("abort_before", 8'(won_o), 8'd1);
        startRound("abort");
        checkOutput("abort_won", 8'(won_o), 8'd0);
        checkOutput("abort_score", 8'(score_o), 8'd1);

        // Sixteen more consecutive wins: streak saturates at 15.
        expScore = 4'd1;
        for (int r = 0; r < 16; r++) begin
            runIdle(int'(expT));
            applyStimulus(1'b0, 1'b1);
            expScore = (expScore == 4'd15) ? 4'd15 : expScore + 4'd1;
            checkOutput("sat_won", 8'(won_o), 8'd1);
            checkOutput("sat_score", 8'(score_o), 8'(expScore));
            startRound("sat_next");
        end
        checkOutput("sat_final", 8'(score_o), 8'd15);

        // Reset in the middle of a round.
        runIdle(5);
        checkOutput("midrst_pre", 8'(elapsed_o), 8'd5);
        rst_i = 1'b1;
        applyStimulus(1'b0, 1'b0);
        rst_i = 1'b0;
        checkOutput("midrst_running", 8'(running_o), 8'd0);
        checkOutput("midrst_score", 8'(score_o), 8'd0);
        checkOutput("midrst_elapsed", 8'(elapsed_o), 8'd0);
        checkOutput("midrst_target", 8'(target_o), 8'd0);
        checkOutput("midrst_won", 8'(won_o), 8'd0);
        checkOutput("midrst_lost", 8'(lost_o), 8'd0);
        startRound("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
